alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  active-low reset, synchronous to clk.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 op  input  4  operation code {funct7[5], funct3}, as produced by the ALU control decoder.
REQ-008 a  input  32  operand A (rs1).
REQ-009 b  input  32  operand B (rs2 or immediate); b[4:0] is the shift amount.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  32  operation result.
REQ-013 zero  output  1  result == 0, for branch decisions.
REQ-014 illegal  output  1  op code not in the defined set.

Function
REQ-015 Accept occurs on a rising edge with in_valid & in_ready; op, a, b SHALL be sampled only at accept and ignored otherwise.
REQ-016 Op decode: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND; arithmetic modulo 2^32, carries discarded.
REQ-017 Codes 1001, 1010, 1011, 1100, 1110, 1111 SHALL be illegal: result=0, zero=1, illegal=1, latency as a non-shift op.
REQ-018 SLT/SLTU: result = {31'b0, compare bit}.
REQ-019 FSM states: IDLE, SHIFT, DONE.
REQ-020 IDLE: in_ready=1, out_valid=0; on accept of a non-shift op, go to DONE with result registered (latency 1 cycle).
REQ-021 On accept of SLL/SRL/SRA with b[4:0]=0: go to DONE with result=a (latency 1).
REQ-022 On accept of a shift with b[4:0]=N>0: load shift register with a and counter with N, then go to SHIFT.
REQ-023 SHIFT: shift one bit per cycle (SLL fills 0 at LSB, SRL fills 0 at MSB, SRA replicates bit 31) and decrement the counter; go to DONE when the counter reaches 0; total latency N+1 cycles; in_ready=0.
REQ-024 DONE: out_valid=1; result, zero and illegal SHALL be held stable while out_ready=0.
REQ-025 DONE with out_ready=1: in_ready=1; if in_valid=1, the new op is accepted in the same cycle (next state per REQ-020..022), else go to IDLE.
REQ-026 Sustained non-shift throughput SHALL be one op per cycle when out_ready=1.
REQ-027 zero and illegal SHALL be registered together with result and SHALL be meaningful only while out_valid=1.
REQ-028 in_ready SHALL be combinational from state and out_ready only, never from in_valid.

Reset
REQ-029 On a clk edge with rst_n=0: state=IDLE, out_valid=0, result=0, zero=0, illegal=0, and the counter and shift register cleared.
REQ-030 While rst_n=0, in_ready SHALL be 0; it becomes 1 in the first cycle after rst_n returns to 1.
REQ-031 Reset during SHIFT or DONE SHALL abandon the operation, with no out_valid pulse afterward.

Verification
REQ-032 ADD a=5, b=7, out_ready=1 -> out_valid next cycle, result=12, zero=0, illegal=0.
REQ-033 SUB a=3, b=3 -> result=0, zero=1; then SLT a=0xFFFFFFFF, b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-034 SRA a=0x80000000, b=4 -> in_ready=0 for 4 cycles, out_valid 5 cycles after accept, result=0xF8000000; SRL with the same operands -> 0x08000000.
REQ-035 Back-to-back ADD ops with out_ready=1 -> one result per cycle; with out_ready=0 for 3 cycles -> result held, in_ready=0, no new accept.
REQ-036 op=1001 -> result=0, zero=1, illegal=1 at latency 1.
REQ-037 SLL a=1, b=31, rst_n=0 asserted for one cycle at SHIFT cycle 10 -> out_valid stays 0, state=IDLE, then a following ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32 integer ALU, single-cycle ops plus a bit-serial shifter under a valid/ready handshake
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic            acc, is_shift, alu_ill;
  logic [XLEN-1:0] alu_res, sh, sh_nxt;
  logic [4:0]      cnt;
  logic [1:0]      sh_op;
  assign in_ready  = rst_n & (state == IDLE | (state == DONE & out_ready));
  assign out_valid = state == DONE;
  assign acc       = in_valid & in_ready;
  assign is_shift  = op == 4'b0001 | op == 4'b0101 | op == 4'b1101;
  // shifts report a here so that a zero shift amount completes in one cycle
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      4'b0000: alu_res = a + b;
      4'b1000: alu_res = a - b;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, a < b};
      4'b0100: alu_res = a ^ b;
      4'b0110: alu_res = a | b;
      4'b0111: alu_res = a & b;
      4'b0001, 4'b0101, 4'b1101: alu_res = a;
      default: alu_ill = 1'b1;
    endcase
  end
  // sh_op = {arith, right}
  assign sh_nxt = sh_op[0] ? {sh_op[1] & sh[XLEN-1], sh[XLEN-1:1]} : {sh[XLEN-2:0], 1'b0};
  always_comb begin
    state_nxt = state;
    if (acc)
      state_nxt = (is_shift && b[4:0] != 5'd0) ? SHIFT : DONE;
    else if (state == SHIFT)
      state_nxt = cnt == 5'd1 ? DONE : SHIFT;
    else if (state == DONE && out_ready)
      state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      sh      <= '0;
      cnt     <= '0;
      sh_op   <= '0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        result  <= alu_res;
        zero    <= alu_res == '0;
        illegal <= alu_ill;
        sh      <= a;
        cnt     <= b[4:0];
        sh_op   <= op[3:2];
      end else if (state == SHIFT) begin
        sh     <= sh_nxt;
        cnt    <= cnt - 5'd1;
        result <= sh_nxt;
        zero   <= sh_nxt == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: vector table, directed handshake/reset sequences and randomized ops against a one-shot arithmetic model
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [3:0]  op;
  logic [31:0] a, b, result;
  int          total = 0;
  int          passed = 0;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        z, il;
    int          lat;
    int          hold;
  } vec_t;
  vec_t vt[13];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endtask

  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic il, output int lat);
    int n;
    n = {27'b0, y[4:0]};
    r = '0;
    il = 1'b0;
    lat = 1;
    case (o)
      4'd0:  r = x + y;
      4'd8:  r = x - y;
      4'd1:  begin r = x << n; lat = n + 1; end
      4'd5:  begin r = x >> n; lat = n + 1; end
      4'd13: begin r = 32'($signed(x) >>> n); lat = n + 1; end
      4'd2:  r = {31'b0, $signed(x) < $signed(y)};
      4'd3:  r = {31'b0, x < y};
      4'd4:  r = x ^ y;
      4'd6:  r = x | y;
      4'd7:  r = x & y;
      default: il = 1'b1;
    endcase
  endfunction

  // issues one op, returns the captured outputs, latency and cycles spent with in_ready low
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int hold,
                        output logic [31:0] r, output logic z, output logic il, output int lat, output int busy);
    int n;
    n = 0;
    busy = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    out_ready = hold == 0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (!in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("result_timeout", {31'b0, out_valid}, 32'd1);
    r = result; z = zero; il = illegal;
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk("hold_result", result, r);
      chk("hold_flags", {30'b0, zero, illegal}, {30'b0, z, il});
      chk("hold_ctrl", {30'b0, out_valid, in_ready}, 32'd2);
      @(negedge clk);
      out_ready = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] r, er;
    logic        z, il, eil;
    int          lat, busy, elat, hold, seen;
    logic [3:0]  o;
    logic [31:0] x, y;
    vt[0]  = '{4'h0, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1,  0};
    vt[1]  = '{4'h8, 32'd3,        32'd3,        32'd0,        1'b1, 1'b0, 1,  0};
    vt[2]  = '{4'h2, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1,  0};
    vt[3]  = '{4'h3, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1,  2};
    vt[4]  = '{4'hD, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 5,  0};
    vt[5]  = '{4'h5, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 5,  1};
    vt[6]  = '{4'h9, 32'd1234,     32'd5,        32'd0,        1'b1, 1'b1, 1,  0};
    vt[7]  = '{4'h1, 32'hDEADBEEF, 32'hFFFFFFE0, 32'hDEADBEEF, 1'b0, 1'b0, 1,  0};
    vt[8]  = '{4'h1, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 32, 3};
    vt[9]  = '{4'h4, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1'b0, 1,  0};
    vt[10] = '{4'h6, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1'b0, 1,  0};
    vt[11] = '{4'h0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1,  0};
    vt[12] = '{4'hF, 32'd9,        32'd9,        32'd0,        1'b1, 1'b1, 1,  2};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {30'b0, zero, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 13; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hold, r, z, il, lat, busy);
      chk($sformatf("vec%0d_result", i), r, vt[i].res);
      chk($sformatf("vec%0d_flags", i), {30'b0, z, il}, {30'b0, vt[i].z, vt[i].il});
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].lat - 1);
    end
    // back-to-back adds, then backpressure with a pending request
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = 4'h0;
    for (int i = 1; i <= 4; i++) begin
      a = i * 100; b = i;
      @(posedge clk); #1;
      chk("b2b_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b_result", result, i * 101);
      @(negedge clk);
    end
    out_ready = 1'b0; a = 32'd7; b = 32'd8;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_result", result, 32'd404);
      chk("stall_ctrl", {30'b0, out_valid, in_ready}, 32'd2);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_result", result, 32'd15);
    @(negedge clk);
    in_valid = 1'b0;
    // reset in the tenth shift cycle of a 31-bit SLL
    @(negedge clk);
    op = 4'h1; a = 32'd1; b = 32'd31; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; seen |= int'(out_valid); end
    chk("rst_abandon_no_valid", seen, 0);
    chk("rst_abandon_idle", {30'b0, in_ready, out_valid}, 32'd2);
    run_op(4'h0, 32'd1, 32'd1, 0, r, z, il, lat, busy);
    chk("post_abandon_add", r, 32'd2);
    chk("post_abandon_lat", lat, 1);
    for (int i = 0; i < 150; i++) begin
      o = 4'($urandom_range(0, 15));
      x = (i % 10 == 0) ? 32'h80000000 : $urandom;
      y = (i % 7 == 0) ? x : $urandom;
      hold = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
      model(o, x, y, er, eil, elat);
      run_op(o, x, y, hold, r, z, il, lat, busy);
      chk($sformatf("rnd%0d_op%h_result", i, o), r, er);
      chk($sformatf("rnd%0d_op%h_flags", i, o), {30'b0, z, il}, {30'b0, er == 32'd0, eil});
      chk($sformatf("rnd%0d_op%h_latency", i, o), lat, elat);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
